// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit path.
// State encoding and frame geometry used by serial_tx8.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  // Baud counter width; a 1-clock bit still needs one flop.
  function automatic int cnt_w(input int cpb);
    return (cpb > 1) ? $clog2(cpb) : 1;
  endfunction

endpackage

// File: rtl/mux8x1.sv
// 8:1 single-bit select mux.
// Picks in[sel] onto y.
module mux8x1 (
  input  logic [7:0] in,
  input  logic [2:0] sel,
  output logic       y
);

  // Plain indexed select.
  always_comb begin
    y = in[sel];
  end

endmodule

// File: rtl/serial_tx8.sv
// UART-style 8-bit frame serializer.
// Start bit, 8 data bits LSB first, stop bit.
module serial_tx8
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t        state, state_n;
  logic [CW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shadow, shadow_n;
  logic          done_n;
  logic          bit_end;
  logic          mux_y;

  assign bit_end = (baud == LAST);

  mux8x1 u_mux (
    .in  (shadow),
    .sel (bit_idx),
    .y   (mux_y)
  );

  // State, counters and shadow word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shadow  <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shadow  <= shadow_n;
      done    <= done_n;
    end
  end

  // Next-state, counter and done decode.
  always_comb begin
    state_n  = state;
    baud_n   = baud;
    bit_n    = bit_idx;
    shadow_n = shadow;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          shadow_n = data_in;
          baud_n   = '0;
          bit_n    = '0;
          state_n  = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_n  = '0;
          state_n = DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          bit_n  = bit_idx + 3'd1;
          if (bit_idx == LAST_BIT) begin
            state_n = STOP;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n  = '0;
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Line decode from registered state only.
  always_comb begin
    tx_out = 1'b1;
    unique case (state)
      IDLE:    tx_out = 1'b1;
      START:   tx_out = 1'b0;
      DATA:    tx_out = mux_y;
      STOP:    tx_out = 1'b1;
      default: tx_out = 1'b1;
    endcase
  end

  // Handshake and status flags.
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

endmodule

// File: tb/tb_serial_tx8.sv
// Bench for serial_tx8 at CPB=4 and CPB=1.
// Line-side scoreboard plus directed steps.
module tb_serial_tx8;

  logic       clk;
  logic       rst;
  logic [7:0] d4, d1;
  logic       v4, v1;
  logic       rdy4, rdy1;
  logic       tx4, tx1;
  logic       busy4, busy1;
  logic       done4, done1;

  int checks;
  int errors;
  int cyc;
  int frames [2];
  int aborted;
  int e0_last [2];
  int e0_prev [2];
  logic [9:0] q4 [$];
  logic [9:0] q1 [$];

  serial_tx8 #(.CLKS_PER_BIT(4)) u4 (
    .clk      (clk),
    .rst      (rst),
    .data_in  (d4),
    .in_valid (v4),
    .in_ready (rdy4),
    .tx_out   (tx4),
    .busy     (busy4),
    .done     (done4)
  );

  serial_tx8 #(.CLKS_PER_BIT(1)) u1 (
    .clk      (clk),
    .rst      (rst),
    .data_in  (d1),
    .in_valid (v1),
    .in_ready (rdy1),
    .tx_out   (tx1),
    .busy     (busy1),
    .done     (done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] mkframe(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Follows one frame from the negedge before its accept edge.
  task automatic frame_mon(input int id);
    int cpb;
    logic [9:0] f;
    logic t, b, r, dn;
    cpb = (id == 1) ? 1 : 4;
    f = 10'h3ff;
    if (id == 1) begin
      chk("unexpected_accept_1", q1.size() > 0, 1);
      if (q1.size() > 0) f = q1.pop_front();
    end else begin
      chk("unexpected_accept_4", q4.size() > 0, 1);
      if (q4.size() > 0) f = q4.pop_front();
    end
    for (int n = 0; n < 10 * cpb; n++) begin
      @(negedge clk);
      if (rst) begin
        aborted++;
        return;
      end
      t  = (id == 1) ? tx1 : tx4;
      b  = (id == 1) ? busy1 : busy4;
      r  = (id == 1) ? rdy1 : rdy4;
      dn = (id == 1) ? done1 : done4;
      if (n % cpb == cpb / 2) chk($sformatf("line_bit%0d_cpb%0d", n / cpb, cpb), t, f[n / cpb]);
      chk("in_frame_busy_ready_done", {b, r, dn}, 3'b100);
    end
    @(negedge clk);
    if (rst) begin
      aborted++;
      return;
    end
    t  = (id == 1) ? tx1 : tx4;
    b  = (id == 1) ? busy1 : busy4;
    r  = (id == 1) ? rdy1 : rdy4;
    dn = (id == 1) ? done1 : done4;
    chk($sformatf("done_cycle_cpb%0d", cpb), {t, b, r, dn}, 4'b1011);
    frames[id]++;
  endtask

  task automatic mon(input int id);
    forever begin
      @(negedge clk);
      while (!rst && ((id == 1) ? (v1 && rdy1) : (v4 && rdy4))) begin
        e0_prev[id] = e0_last[id];
        e0_last[id] = cyc + 1;
        frame_mon(id);
      end
    end
  endtask

  task automatic wait_ready(input int id);
    bit got;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((id == 1) ? rdy1 : rdy4) begin
        got = 1;
        break;
      end
    end
    chk("accept_timeout", got, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input logic [7:0] d);
    if (id == 1) begin
      v1 = 1'b1;
      d1 = d;
      q1.push_back(mkframe(d));
    end else begin
      v4 = 1'b1;
      d4 = d;
      q4.push_back(mkframe(d));
    end
    wait_ready(id);
    if (id == 1) v1 = 1'b0;
    else v4 = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    aborted = 0;
    frames  = '{0, 0};
    e0_last = '{0, 0};
    e0_prev = '{0, 0};
    rst = 1'b1;
    v4 = 1'b0;
    v1 = 1'b0;
    d4 = 8'h00;
    d1 = 8'h00;
    #3;
    chk("reset_u4", {tx4, rdy4, busy4, done4}, 4'b1100);
    chk("reset_u1", {tx1, rdy1, busy1, done1}, 4'b1100);
    tick(2);
    rst = 1'b0;
    fork
      mon(0);
      mon(1);
    join_none
    tick(2);

    send(0, 8'hA5);
    tick(45);
    chk("frames_a5", frames[0], 1);

    v4 = 1'b1;
    d4 = 8'h00;
    q4.push_back(mkframe(8'h00));
    wait_ready(0);
    d4 = 8'hFF;
    q4.push_back(mkframe(8'hFF));
    wait_ready(0);
    v4 = 1'b0;
    tick(45);
    chk("frames_b2b", frames[0], 3);
    chk("b2b_accept_gap", e0_last[0] - e0_prev[0], 41);

    send(1, 8'h81);
    tick(15);
    chk("frames_cpb1", frames[1], 1);

    send(0, 8'h3C);
    repeat (30) begin
      @(posedge clk);
      #1;
      v4 = ~v4;
      d4 = 8'($urandom);
    end
    v4 = 1'b0;
    tick(15);
    chk("frames_3c", frames[0], 4);
    chk("queue_after_3c", q4.size(), 0);

    send(0, 8'hC3);
    repeat (21) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset_out", {tx4, rdy4, busy4, done4}, 4'b1100);
    tick(1);
    chk("reset_hold_done", done4, 0);
    rst = 1'b0;
    tick(2);
    chk("aborted_count", aborted, 1);
    chk("frames_after_abort", frames[0], 4);
    chk("no_retransmit", {tx4, busy4}, 2'b10);

    send(0, 8'h5A);
    tick(45);
    chk("frames_5a", frames[0], 5);

    repeat (100) begin
      @(negedge clk);
      chk("idle_u4", {tx4, busy4, done4}, 3'b100);
      chk("idle_u1", {tx1, busy1, done1}, 3'b100);
    end

    chk("queue4_empty", q4.size(), 0);
    chk("queue1_empty", q1.size(), 0);
    chk("frames_final_u1", frames[1], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
